// File: rtl/reset_sequencer.sv
// Multi-output reset sequencer.
// Takes the board reset, a bouncy reset button and a soft-reset request.
// Drives NUM_OUT active-low resets that assert together and release one at a
// time after a hold period. Reports completion and the cause of the last reset.
module reset_sequencer #(
    parameter int NUM_OUT        = 3,
    parameter int HOLD_CYCLES    = 240,
    parameter int STAGGER_CYCLES = 16,
    parameter int FILTER_LEN     = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               btn_rst_n,
    input  logic               soft_rst_req,
    output logic [NUM_OUT-1:0] reset_n,
    output logic               rst_done,
    output logic [1:0]         rst_cause
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_BTN  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    // The cycle counter is cleared on every state change, so it only needs to
    // reach the larger of the two terminal counts.
    localparam int MAX_CNT = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int FW      = $clog2(FILTER_LEN + 1);
    localparam int IW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [FW-1:0] FLT_LAST  = FW'(FILTER_LEN - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

    // ------------------------------------------------------------------
    // Board reset synchroniser: assert immediately, release on clk.
    // ------------------------------------------------------------------
    logic [1:0] por_sync_q;
    logic       por_ok;

    // Shift a constant one through the chain once rstn is released.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state is always assigned with <=, so every flop
        // samples the pre-edge value of its neighbours.
        if (!rstn) por_sync_q <= 2'b00;
        else       por_sync_q <= {por_sync_q[0], 1'b1};
    end

    assign por_ok = por_sync_q[1];

    // ------------------------------------------------------------------
    // Button path: synchroniser followed by a debouncer.
    // ------------------------------------------------------------------
    logic [1:0]    btn_sync_q;
    logic          btn_sample;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          btn_ok_q, btn_ok_d;
    logic          btn_ok_prev_q;
    logic          btn_fall;

    // Two-flop synchroniser; resets to the released (high) level so a
    // board reset never looks like a button press.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) btn_sync_q <= 2'b11;
        else       btn_sync_q <= {btn_sync_q[0], btn_rst_n};
    end

    assign btn_sample = btn_sync_q[1];

    // Debouncer: the sample must disagree with btn_ok for FILTER_LEN
    // consecutive cycles before btn_ok follows it.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        flt_cnt_d = flt_cnt_q;
        btn_ok_d  = btn_ok_q;
        if (btn_sample == btn_ok_q) begin
            flt_cnt_d = '0;
        end else if (flt_cnt_q == FLT_LAST) begin
            btn_ok_d  = btn_sample;
            flt_cnt_d = '0;
        end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
        end
    end

    // Debouncer state plus a delayed copy used for falling-edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flt_cnt_q     <= '0;
            btn_ok_q      <= 1'b1;
            btn_ok_prev_q <= 1'b1;
        end else begin
            flt_cnt_q     <= flt_cnt_d;
            btn_ok_q      <= btn_ok_d;
            btn_ok_prev_q <= btn_ok_q;
        end
    end

    assign btn_fall = btn_ok_prev_q & ~btn_ok_q;

    // ------------------------------------------------------------------
    // Sequencing FSM with registered outputs.
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_OUT-1:0] reset_n_q, reset_n_d;
    logic               rst_done_q, rst_done_d;
    logic [1:0]         cause_q, cause_d;

    // Next-state and output logic; the button override comes last so it
    // beats the soft request on the same edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        reset_n_d  = reset_n_q;
        rst_done_d = rst_done_q;
        cause_d    = cause_q;

        unique case (state_q)
            ST_ASSERT: begin
                reset_n_d  = '0;
                rst_done_d = 1'b0;
                cnt_d      = '0;
                idx_d      = '0;
                if (por_ok && btn_ok_q) state_d = ST_HOLD;
            end

            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    reset_n_d[0] = 1'b1;
                    cnt_d        = '0;
                    if (NUM_OUT == 1) begin
                        state_d    = ST_RUN;
                        rst_done_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                        idx_d   = IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (cnt_q == STAG_LAST) begin
                    reset_n_d[idx_q] = 1'b1;
                    cnt_d            = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d    = ST_RUN;
                        rst_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                rst_done_d = 1'b1;
                if (soft_rst_req) begin
                    state_d    = ST_ASSERT;
                    reset_n_d  = '0;
                    rst_done_d = 1'b0;
                    cause_d    = CAUSE_SOFT;
                end
            end

            default: state_d = ST_ASSERT;
        endcase

        // A button press restarts the sequence from any state.
        if (btn_fall) begin
            state_d    = ST_ASSERT;
            reset_n_d  = '0;
            rst_done_d = 1'b0;
            cnt_d      = '0;
            idx_d      = '0;
            cause_d    = CAUSE_BTN;
        end
    end

    // FSM state, counters and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= '0;
            idx_q      <= '0;
            reset_n_q  <= '0;
            rst_done_q <= 1'b0;
            cause_q    <= CAUSE_POR;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            reset_n_q  <= reset_n_d;
            rst_done_q <= rst_done_d;
            cause_q    <= cause_d;
        end
    end

    assign reset_n   = reset_n_q;
    assign rst_done  = rst_done_q;
    assign rst_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters.
// Observed vector is {reset_n[2:0], rst_done, rst_cause[1:0]}.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       btn_rst_n;
    logic       soft_rst_req;
    logic [2:0] reset_n;
    logic       rst_done;
    logic [1:0] rst_cause;

    int n_checks = 0;
    int n_fail   = 0;

    reset_sequencer #(
        .NUM_OUT        (3),
        .HOLD_CYCLES    (240),
        .STAGGER_CYCLES (16),
        .FILTER_LEN     (4)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .btn_rst_n    (btn_rst_n),
        .soft_rst_req (soft_rst_req),
        .reset_n      (reset_n),
        .rst_done     (rst_done),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [5:0] obs();
        return {reset_n, rst_done, rst_cause};
    endfunction

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn         = 1'b0;
        btn_rst_n    = 1'b1;
        soft_rst_req = 1'b0;
        #2;
        n_checks++;
        if (obs() !== 6'b000_0_00) begin
            n_fail++;
            $display("FAIL reset_initial: got %b expected %b", obs(), 6'b000_0_00);
        end
        step(5);
        n_checks++;
        if (obs() !== 6'b000_0_00) begin
            n_fail++;
            $display("FAIL reset_clocked: got %b expected %b", obs(), 6'b000_0_00);
        end
    endtask

    // Called 1 ns after a rising edge with rstn low; next edge is E0.
    task automatic test_power_on(input string tag);
        rstn = 1'b1;
        step(242); // past E241
        n_checks++;
        if (obs() !== 6'b000_0_00) begin
            n_fail++;
            $display("FAIL %s_e241: got %b expected %b", tag, obs(), 6'b000_0_00);
        end
        step(1);   // past E242
        n_checks++;
        if (obs() !== 6'b001_0_00) begin
            n_fail++;
            $display("FAIL %s_e242: got %b expected %b", tag, obs(), 6'b001_0_00);
        end
        step(15);  // past E257
        n_checks++;
        if (obs() !== 6'b001_0_00) begin
            n_fail++;
            $display("FAIL %s_e257: got %b expected %b", tag, obs(), 6'b001_0_00);
        end
        step(1);   // past E258
        n_checks++;
        if (obs() !== 6'b011_0_00) begin
            n_fail++;
            $display("FAIL %s_e258: got %b expected %b", tag, obs(), 6'b011_0_00);
        end
        step(15);  // past E273
        n_checks++;
        if (obs() !== 6'b011_0_00) begin
            n_fail++;
            $display("FAIL %s_e273: got %b expected %b", tag, obs(), 6'b011_0_00);
        end
        step(1);   // past E274
        n_checks++;
        if (obs() !== 6'b111_1_00) begin
            n_fail++;
            $display("FAIL %s_e274: got %b expected %b", tag, obs(), 6'b111_1_00);
        end
    endtask

    task automatic test_btn_glitch();
        btn_rst_n = 1'b0;
        step(3);   // low sampled on 3 edges
        btn_rst_n = 1'b1;
        step(2);
        n_checks++;
        if (obs() !== 6'b111_1_00) begin
            n_fail++;
            $display("FAIL glitch_mid: got %b expected %b", obs(), 6'b111_1_00);
        end
        step(10);
        n_checks++;
        if (obs() !== 6'b111_1_00) begin
            n_fail++;
            $display("FAIL glitch_end: got %b expected %b", obs(), 6'b111_1_00);
        end
    endtask

    task automatic test_btn_press();
        btn_rst_n = 1'b0;  // next edge is B0
        step(6);           // past B5: btn_ok just fell, outputs unchanged
        n_checks++;
        if (obs() !== 6'b111_1_00) begin
            n_fail++;
            $display("FAIL press_b5: got %b expected %b", obs(), 6'b111_1_00);
        end
        step(1);           // past B6
        n_checks++;
        if (obs() !== 6'b000_0_01) begin
            n_fail++;
            $display("FAIL press_b6: got %b expected %b", obs(), 6'b000_0_01);
        end
        step(13);          // past B19: 20 low samples in total
        btn_rst_n = 1'b1;  // first high sample at B20, btn_ok high after B25
        step(246);         // past B265
        n_checks++;
        if (obs() !== 6'b000_0_01) begin
            n_fail++;
            $display("FAIL press_b265: got %b expected %b", obs(), 6'b000_0_01);
        end
        step(1);           // past B266 = 241 after btn_ok rise
        n_checks++;
        if (obs() !== 6'b001_0_01) begin
            n_fail++;
            $display("FAIL press_b266: got %b expected %b", obs(), 6'b001_0_01);
        end
        step(31);          // past B297
        n_checks++;
        if (obs() !== 6'b011_0_01) begin
            n_fail++;
            $display("FAIL press_b297: got %b expected %b", obs(), 6'b011_0_01);
        end
        step(1);           // past B298
        n_checks++;
        if (obs() !== 6'b111_1_01) begin
            n_fail++;
            $display("FAIL press_b298: got %b expected %b", obs(), 6'b111_1_01);
        end
    endtask

    task automatic test_soft();
        soft_rst_req = 1'b1;  // next edge is S0
        step(1);
        soft_rst_req = 1'b0;
        n_checks++;
        if (obs() !== 6'b000_0_10) begin
            n_fail++;
            $display("FAIL soft_s0: got %b expected %b", obs(), 6'b000_0_10);
        end
        step(240);            // past S240
        n_checks++;
        if (obs() !== 6'b000_0_10) begin
            n_fail++;
            $display("FAIL soft_s240: got %b expected %b", obs(), 6'b000_0_10);
        end
        step(1);              // past S241
        n_checks++;
        if (obs() !== 6'b001_0_10) begin
            n_fail++;
            $display("FAIL soft_s241: got %b expected %b", obs(), 6'b001_0_10);
        end
        step(31);             // past S272
        n_checks++;
        if (obs() !== 6'b011_0_10) begin
            n_fail++;
            $display("FAIL soft_s272: got %b expected %b", obs(), 6'b011_0_10);
        end
        step(1);              // past S273
        n_checks++;
        if (obs() !== 6'b111_1_10) begin
            n_fail++;
            $display("FAIL soft_s273: got %b expected %b", obs(), 6'b111_1_10);
        end
    endtask

    task automatic test_soft_outside_run();
        soft_rst_req = 1'b1;  // S0
        step(1);
        soft_rst_req = 1'b0;
        step(257);            // past S257
        n_checks++;
        if (obs() !== 6'b011_0_10) begin
            n_fail++;
            $display("FAIL soft_ign_s257: got %b expected %b", obs(), 6'b011_0_10);
        end
        step(2);              // past S259
        soft_rst_req = 1'b1;  // sampled at S260, in RELEASE
        step(1);
        soft_rst_req = 1'b0;
        step(12);             // past S272
        n_checks++;
        if (obs() !== 6'b011_0_10) begin
            n_fail++;
            $display("FAIL soft_ign_s272: got %b expected %b", obs(), 6'b011_0_10);
        end
        step(1);              // past S273
        n_checks++;
        if (obs() !== 6'b111_1_10) begin
            n_fail++;
            $display("FAIL soft_ign_s273: got %b expected %b", obs(), 6'b111_1_10);
        end
    endtask

    task automatic test_rstn_mid_release();
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        step(262);            // past S262, reset_n = 011
        n_checks++;
        if (obs() !== 6'b011_0_10) begin
            n_fail++;
            $display("FAIL rstn_mid_pre: got %b expected %b", obs(), 6'b011_0_10);
        end
        rstn = 1'b0;
        #1;                   // no clock edge in between
        n_checks++;
        if (obs() !== 6'b000_0_00) begin
            n_fail++;
            $display("FAIL rstn_mid_async: got %b expected %b", obs(), 6'b000_0_00);
        end
        step(4);
        n_checks++;
        if (obs() !== 6'b000_0_00) begin
            n_fail++;
            $display("FAIL rstn_mid_held: got %b expected %b", obs(), 6'b000_0_00);
        end
        test_power_on("rstn_restart");
    endtask

    initial begin
        test_reset();
        test_power_on("poweron");
        test_btn_glitch();
        test_btn_press();
        test_soft();
        test_soft_outside_run();
        test_rstn_mid_release();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
